// File: rtl/fb_pkg.sv
// fb_pkg: shared frame buffer geometry, fetch state and capture-pipe types
package fb_pkg;
  localparam int FB_WIDTH = 640;
  localparam int FB_HEIGHT = 480;
  localparam int V_TOTAL = 525;
  localparam int WORDS_PER_LINE = 160;
  localparam logic [19:0] FB1_BASE = 20'h12C00;
  typedef logic [3:0] palette_idx_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} fetch_state_t;
  typedef struct packed {
    logic       v;
    logic [7:0] w;
    logic [1:0] g;
  } cap_t;
  function automatic logic [19:0] line_addr(input logic [19:0] base, input logic [9:0] y);
    return base + ({10'd0, y} << 7) + ({10'd0, y} << 5);
  endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: 2x160x16 dual-port RAM, bank bit is the address MSB, registered read
module line_buffer (
  input  logic        clk,
  input  logic        we,
  input  logic        wbank,
  input  logic [7:0]  waddr,
  input  logic [15:0] wdata,
  input  logic        rbank,
  input  logic [7:0]  raddr,
  output logic [15:0] rdata
);
  logic [15:0] mem [2][160];
  always_ff @(posedge clk) begin
    if (we) mem[wbank][waddr] <= wdata;
    rdata <= mem[rbank][raddr];
  end
endmodule

// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: scanline SRAM fetch into ping-pong line buffer, 4-bit pixel out (FBR_UNDERRUN_CNT_EN adds underrun_cnt)
module frame_buffer_reader
  import fb_pkg::*;
#(
  parameter int          READ_LATENCY = 2,
  parameter logic [19:0] FB1_BASE     = fb_pkg::FB1_BASE
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        even_frame,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        sram_req,
  input  logic        sram_grant,
  output logic [19:0] sram_addr,
  input  logic [15:0] sram_rdata,
  output logic [3:0]  pixel_idx,
  output logic        underrun
`ifdef FBR_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);
  fetch_state_t state;
  cap_t         pipe [READ_LATENCY];
  logic         at640_q, sel, front, blank_q;
  logic [1:0]   valid, gen, nib_q;
  logic [7:0]   issue_cnt, recv_cnt;
  logic [9:0]   t;
  logic [15:0]  lb_rdata;
  logic         trig, start, ovr, cap, sel_n;
  palette_idx_t nibble;
  always_comb begin
    t     = DrawY == 10'(V_TOTAL - 1) ? 10'd0 : DrawY + 10'd1;
    trig  = DrawX == 10'(FB_WIDTH) && !at640_q;
    start = trig && t < 10'(FB_HEIGHT);
    ovr   = start && state != IDLE;
    sel_n = t == 10'd0 ? ~even_frame : sel;
    cap   = pipe[READ_LATENCY-1].v && pipe[READ_LATENCY-1].g == gen && !start;
    nibble = lb_rdata[{nib_q, 2'b00} +: 4];
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      sram_req  <= 1'b0;
      sram_addr <= '0;
      underrun  <= 1'b0;
      valid     <= '0;
      sel       <= 1'b0;
      front     <= 1'b0;
      gen       <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      at640_q   <= 1'b0;
      for (int k = 0; k < READ_LATENCY; k++) pipe[k] <= '0;
    end else begin
      at640_q <= DrawX == 10'(FB_WIDTH);
      pipe[0] <= '{v: sram_req && sram_grant, w: issue_cnt, g: gen};
      for (int k = 1; k < READ_LATENCY; k++) pipe[k] <= pipe[k-1];
      if (start) begin
        if (ovr) underrun <= 1'b1;
        gen          <= gen + 2'd1;
        state        <= ISSUE;
        sram_req     <= 1'b1;
        issue_cnt    <= '0;
        recv_cnt     <= '0;
        valid[~front] <= 1'b0;
        sel          <= sel_n;
        sram_addr    <= line_addr(sel_n ? FB1_BASE : 20'd0, t);
      end else begin
        if (sram_req && sram_grant) begin
          issue_cnt <= issue_cnt + 8'd1;
          sram_addr <= sram_addr + 20'd1;
          if (issue_cnt == 8'(WORDS_PER_LINE - 1)) begin
            sram_req <= 1'b0;
            state    <= DRAIN;
          end
        end
        if (cap) begin
          recv_cnt <= recv_cnt + 8'd1;
          if (recv_cnt == 8'(WORDS_PER_LINE - 1)) begin
            state         <= IDLE;
            valid[~front] <= 1'b1;
            front         <= ~front;
          end
        end
      end
    end
  end
`ifdef FBR_UNDERRUN_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) underrun_cnt <= '0;
    else if (ovr && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif
  line_buffer u_lb (
    .clk  (Clk),
    .we   (cap && !Reset),
    .wbank(~front),
    .waddr(pipe[READ_LATENCY-1].w),
    .wdata(sram_rdata),
    .rbank(front),
    .raddr(DrawX[9:2]),
    .rdata(lb_rdata)
  );
  always_ff @(posedge Clk) begin
    if (Reset) begin
      blank_q   <= 1'b1;
      nib_q     <= '0;
      pixel_idx <= '0;
    end else begin
      blank_q   <= DrawX >= 10'(FB_WIDTH) || DrawY >= 10'(FB_HEIGHT) || !valid[front];
      nib_q     <= DrawX[1:0];
      pixel_idx <= blank_q ? 4'd0 : nibble;
    end
  end
endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb_frame_buffer_reader: directed scoreboard bench for frame_buffer_reader
module tb_frame_buffer_reader;
  localparam int RL = 2;
  localparam logic [19:0] FB1 = 20'h12C00;
  logic        Clk = 1'b0;
  logic        Reset, even_frame, sram_req, sram_grant, underrun;
  logic [9:0]  DrawX, DrawY;
  logic [19:0] sram_addr;
  logic [15:0] sram_rdata;
  logic [3:0]  pixel_idx;
`ifdef FBR_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif
  int total = 0, bad = 0, cyc = 0, gmode = 1;
  logic [19:0] aq[$];
  int          pdue[$];
  logic [3:0]  pexp[$];
  logic        rd_v [RL];
  logic [19:0] rd_a [RL];
  always #10 Clk = ~Clk;
  frame_buffer_reader #(.READ_LATENCY(RL), .FB1_BASE(FB1)) dut (
    .Clk(Clk), .Reset(Reset), .even_frame(even_frame), .DrawX(DrawX), .DrawY(DrawY),
    .sram_req(sram_req), .sram_grant(sram_grant), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .pixel_idx(pixel_idx), .underrun(underrun)
`ifdef FBR_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );
  function automatic logic [15:0] sdata(input logic [19:0] a);
    return a[15:0] ^ 16'h4321;
  endfunction
  always @(posedge Clk) begin
    rd_v[0] <= sram_req && sram_grant;
    rd_a[0] <= sram_addr;
    for (int k = 1; k < RL; k++) begin
      rd_v[k] <= rd_v[k-1];
      rd_a[k] <= rd_a[k-1];
    end
  end
  assign sram_rdata = rd_v[RL-1] ? sdata(rd_a[RL-1]) : 16'hFFFF;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  always @(negedge Clk) begin
    if (sram_req && sram_grant) begin
      total++;
      assert (aq.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_read: got addr %0h expected no read (cycle %0d)", sram_addr, cyc);
      end
      if (aq.size() != 0) chk("sram_addr", sram_addr, aq.pop_front());
    end
    if (pdue.size() != 0 && pdue[0] == cyc) begin
      void'(pdue.pop_front());
      chk("pixel_idx", pixel_idx, pexp.pop_front());
    end
  end
  task automatic tick;
    @(posedge Clk);
    #1;
    cyc++;
    sram_grant = gmode == 1 ? 1'b1 : gmode == 2 ? cyc[0] : 1'b0;
  endtask
  task automatic push_line(input logic [19:0] base, input int y);
    for (int w = 0; w < 160; w++) aq.push_back(base + 20'(y * 160 + w));
  endtask
  task automatic trigger(input int y);
    DrawY = 10'(y);
    DrawX = 10'd639;
    tick;
    DrawX = 10'd640;
    tick;
    DrawX = 10'd700;
  endtask
  task automatic wait_fetch(input string tag);
    for (int i = 0; i < 1000 && aq.size() != 0; i++) tick;
    chk(tag, aq.size(), 0);
    aq.delete();
    repeat (RL + 3) tick;
  endtask
  task automatic expect_pix(input logic [3:0] e);
    pdue.push_back(cyc + 2);
    pexp.push_back(e);
  endtask
  task automatic check_line(input int y, input logic [19:0] base);
    logic [15:0] wd;
    DrawY = 10'(y);
    for (int x = 0; x < 640; x++) begin
      DrawX = 10'(x);
      wd = sdata(base + 20'(y * 160 + x / 4));
      expect_pix(wd[4*(x%4) +: 4]);
      tick;
    end
    DrawX = 10'd700;
    expect_pix(4'd0);
    repeat (3) tick;
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    Reset = 1'b1;
    even_frame = 1'b1;
    sram_grant = 1'b1;
    DrawX = 10'd700;
    DrawY = 10'd0;
    repeat (3) tick;
    Reset = 1'b0;
    tick;
    chk("reset_req", sram_req, 0);
    chk("reset_addr", sram_addr, 0);
    chk("reset_pix", pixel_idx, 0);
    chk("reset_underrun", underrun, 0);
`ifdef FBR_UNDERRUN_CNT_EN
    chk("reset_cnt", underrun_cnt, 0);
`endif
    DrawY = 10'd524;
    DrawX = 10'd639;
    tick;
    push_line(20'd0, 0);
    DrawX = 10'd640;
    chk("req_at_trigger", sram_req, 0);
    tick;
    chk("req_after_trigger", sram_req, 1);
    chk("first_addr", sram_addr, 0);
    DrawX = 10'd700;
    wait_fetch("fetch_line0_buf0");
    DrawY = 10'd0;
    for (int x = 0; x < 4; x++) begin
      DrawX = 10'(x);
      expect_pix(4'(x + 1));
      tick;
    end
    repeat (3) tick;
    check_line(0, 20'd0);
    even_frame = 1'b0;
    push_line(FB1, 0);
    trigger(524);
    wait_fetch("fetch_line0_buf1");
    even_frame = 1'b1;
    push_line(FB1, 5);
    trigger(4);
    wait_fetch("fetch_line5_buf1");
    check_line(5, FB1);
    gmode = 2;
    push_line(FB1, 10);
    trigger(9);
    wait_fetch("fetch_toggle_grant");
    chk("no_underrun_toggle", underrun, 0);
    check_line(10, FB1);
    gmode = 1;
    DrawY = 10'd490;
    DrawX = 10'd10;
    expect_pix(4'd0);
    tick;
    DrawY = 10'd10;
    DrawX = 10'd700;
    expect_pix(4'd0);
    repeat (3) tick;
    trigger(480);
    tick;
    chk("no_fetch_481", sram_req, 0);
    trigger(523);
    tick;
    chk("no_fetch_524", sram_req, 0);
    trigger(479);
    repeat (3) tick;
    chk("no_fetch_480", sram_req, 0);
    gmode = 0;
    trigger(19);
    repeat (1600) tick;
    chk("pending_no_underrun", underrun, 0);
    chk("pending_req", sram_req, 1);
    push_line(FB1, 21);
    DrawY = 10'd20;
    DrawX = 10'd639;
    tick;
    DrawX = 10'd640;
    tick;
    DrawX = 10'd700;
    chk("underrun_set", underrun, 1);
`ifdef FBR_UNDERRUN_CNT_EN
    chk("underrun_cnt", underrun_cnt, 1);
`endif
    gmode = 1;
    wait_fetch("fetch_after_underrun");
    check_line(21, FB1);
    chk("underrun_sticky", underrun, 1);
    push_line(FB1, 30);
    trigger(29);
    for (int i = 0; i < 400 && aq.size() > 80; i++) tick;
    chk("issued_80", aq.size(), 80);
    Reset = 1'b1;
    tick;
    chk("req_after_reset", sram_req, 0);
    aq.delete();
    Reset = 1'b0;
    tick;
    chk("underrun_cleared", underrun, 0);
    chk("addr_cleared", sram_addr, 0);
    DrawY = 10'd30;
    DrawX = 10'd5;
    expect_pix(4'd0);
    tick;
    DrawX = 10'd700;
    repeat (3) tick;
    push_line(20'd0, 31);
    trigger(30);
    wait_fetch("fetch_after_reset");
    check_line(31, 20'd0);
    chk("pix_queue_empty", pdue.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
